// File: rtl/dcache_2way.sv
// Two-way set-associative, write-through, no-write-allocate data cache with a freeze
// handshake towards the pipeline and saturating hit/miss counters.
module dcache_2way #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned IDX_W  = 6,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              sram_req,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    input  logic              sram_ready,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);
    localparam int unsigned TAG_W = ADDR_W - 2 - IDX_W;
    localparam int unsigned SETS  = 1 << IDX_W;

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    state_e              r_state;
    logic [SETS-1:0]     r_valid0;
    logic [SETS-1:0]     r_valid1;
    logic [SETS-1:0]     r_lru;
    logic [TAG_W-1:0]    r_tag0  [SETS];
    logic [TAG_W-1:0]    r_tag1  [SETS];
    logic [DATA_W-1:0]   r_data0 [SETS];
    logic [DATA_W-1:0]   r_data1 [SETS];
    logic [DATA_W-1:0]   r_result;
    logic [CNT_W-1:0]    r_hit_cnt;
    logic [CNT_W-1:0]    r_miss_cnt;
    logic                r_sram_req;
    logic                r_sram_we;

    logic [IDX_W-1:0]    w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic                w_hit0;
    logic                w_hit1;
    logic                w_hit;
    logic                w_victim;
    logic                w_fill;
    logic                w_wr_upd;
    logic [1:0]          w_unused_addr;

    assign w_idx         = addr[IDX_W+1:2];
    assign w_tag         = addr[ADDR_W-1:IDX_W+2];
    assign w_unused_addr = addr[1:0];
    assign w_hit0        = r_valid0[w_idx] && (r_tag0[w_idx] == w_tag);
    assign w_hit1        = r_valid1[w_idx] && (r_tag1[w_idx] == w_tag);
    assign w_hit         = w_hit0 || w_hit1;
    // Fill an empty way first; only evict the LRU way when the set is full.
    assign w_victim      = !r_valid0[w_idx] ? 1'b0 : (!r_valid1[w_idx] ? 1'b1 : r_lru[w_idx]);
    assign w_fill        = (r_state == StRead) && sram_ready;
    assign w_wr_upd      = (r_state == StWrite) && sram_ready && w_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_valid0   <= '0;
            r_valid1   <= '0;
            r_lru      <= '0;
            r_result   <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            r_sram_req <= 1'b0;
            r_sram_we  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (mem_w_en) begin
                        r_state    <= StWrite;
                        r_sram_req <= 1'b1;
                        r_sram_we  <= 1'b1;
                    end else if (mem_r_en) begin
                        if (w_hit) begin
                            r_lru[w_idx] <= w_hit0;
                            if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
                        end else begin
                            r_state    <= StRead;
                            r_sram_req <= 1'b1;
                            r_sram_we  <= 1'b0;
                            if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
                        end
                    end
                end
                StRead: begin
                    if (sram_ready) begin
                        if (w_victim) r_valid1[w_idx] <= 1'b1;
                        else          r_valid0[w_idx] <= 1'b1;
                        r_lru[w_idx] <= ~w_victim;
                        r_result     <= sram_rdata;
                        r_sram_req   <= 1'b0;
                        r_state      <= StDone;
                    end
                end
                StWrite: begin
                    if (sram_ready) begin
                        if (w_hit) r_lru[w_idx] <= w_hit0;
                        r_sram_req <= 1'b0;
                        r_state    <= StDone;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Tag/data arrays carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            if (w_victim) begin
                r_tag1[w_idx]  <= w_tag;
                r_data1[w_idx] <= sram_rdata;
            end else begin
                r_tag0[w_idx]  <= w_tag;
                r_data0[w_idx] <= sram_rdata;
            end
        end
        if (w_wr_upd) begin
            if (w_hit0) r_data0[w_idx] <= wdata;
            else        r_data1[w_idx] <= wdata;
        end
    end

    always_comb begin
        ready = 1'b0;
        rdata = '0;
        case (r_state)
            StIdle: begin
                ready = !mem_w_en && (!mem_r_en || w_hit);
                rdata = w_hit1 ? r_data1[w_idx] : r_data0[w_idx];
            end
            StDone: begin
                ready = 1'b1;
                rdata = r_result;
            end
            default: ;
        endcase
    end

    assign sram_req   = r_sram_req;
    assign sram_we    = r_sram_we;
    assign sram_addr  = {addr[ADDR_W-1:2], 2'b00};
    assign sram_wdata = wdata;
    assign hit_cnt    = r_hit_cnt;
    assign miss_cnt   = r_miss_cnt;

endmodule

// File: tb/tb_dcache_2way.sv
// Bench for dcache_2way: randomized loads/stores against a recency-list cache model and a
// flat memory model; a scoreboard queue is drained by a monitor whenever the DUT completes.
module tb_dcache_2way;
    localparam int CW = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_r_en = 1'b0;
    logic        mem_w_en = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready;
    logic        sram_req;
    logic        sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata = '0;
    logic        sram_ready = 1'b0;
    logic [CW-1:0] hit_cnt;
    logic [CW-1:0] miss_cnt;

    dcache_2way #(.DATA_W(32), .ADDR_W(32), .IDX_W(6), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .addr(addr),
        .wdata(wdata), .rdata(rdata), .ready(ready), .sram_req(sram_req), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_ready(sram_ready), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_load;
        logic [31:0] data;
        int          stalls;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Memory seen by the SRAM model and the reference view of the same memory.
    logic [31:0] sram_mem [logic [31:0]];
    logic [31:0] ref_mem  [logic [31:0]];

    function automatic logic [31:0] defv(input logic [31:0] a);
        return a * 32'h9E3779B1 + 32'h0123_4567;
    endfunction

    // Cache reference: per set, a recency list of at most two tags.
    int          m_n   [64];
    logic [31:0] m_mru [64];
    logic [31:0] m_lru [64];
    int          hits = 0;
    int          misses = 0;

    function automatic bit m_present(input int s, input logic [31:0] t);
        return (m_n[s] >= 1 && m_mru[s] == t) || (m_n[s] == 2 && m_lru[s] == t);
    endfunction

    function automatic void m_touch(input int s, input logic [31:0] t);
        if (m_mru[s] != t) begin
            m_lru[s] = m_mru[s];
            m_mru[s] = t;
        end
    endfunction

    function automatic void m_insert(input int s, input logic [31:0] t);
        if (m_n[s] >= 1) m_lru[s] = m_mru[s];
        m_mru[s] = t;
        if (m_n[s] < 2) m_n[s]++;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < 64; i++) m_n[i] = 0;
        hits = 0;
        misses = 0;
    endfunction

    function automatic logic [63:0] sat(input int x);
        return (x > 3) ? 64'd3 : 64'(x);
    endfunction

    // SRAM model: raises sram_ready in the s_lat-th cycle of an access.
    int          s_cnt = 0;
    int          s_lat = 1;
    bit          exp_sram = 0;
    bit          exp_we = 0;
    logic [31:0] exp_addr = '0;

    always begin
        @(posedge clk);
        #1;
        if (sram_req && !rst) begin
            s_cnt++;
            if (s_cnt == 1) begin
                check("sram_access_expected", 64'(1), 64'(exp_sram));
                check("sram_addr", 64'(sram_addr), 64'(exp_addr));
                check("sram_we", 64'(sram_we), 64'(exp_we));
            end
            if (s_cnt == s_lat) begin
                sram_ready = 1'b1;
                if (sram_we) sram_mem[sram_addr] = sram_wdata;
                else sram_rdata = sram_mem.exists(sram_addr) ? sram_mem[sram_addr]
                                                             : defv(sram_addr);
            end else begin
                sram_ready = 1'b0;
                sram_rdata = $urandom;
            end
        end else begin
            s_cnt = 0;
            sram_ready = 1'b0;
            sram_rdata = $urandom;
        end
    end

    // Monitor: count freeze cycles, compare on every completed request.
    bit   mon_en = 1'b1;
    int   mon_stall = 0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst || !mon_en) begin
            mon_stall = 0;
        end else if (mem_r_en || mem_w_en) begin
            if (!ready) begin
                mon_stall++;
            end else if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_completion: got ready=1, expected no pending request");
            end else begin
                mon_e = sb_q.pop_front();
                check({mon_e.name, "_stall"}, 64'(mon_stall), 64'(mon_e.stalls));
                if (mon_e.is_load) check({mon_e.name, "_rdata"}, 64'(rdata), 64'(mon_e.data));
                mon_stall = 0;
            end
        end
    end

    task automatic issue(input bit ld, input logic [31:0] a, input logic [31:0] d,
                         input int lat, input string nm);
        exp_t        e;
        int          s;
        logic [31:0] t;
        logic [31:0] wa;
        bit          hit;
        int          n;
        s   = int'(a[7:2]);
        t   = a >> 8;
        wa  = {a[31:2], 2'b00};
        hit = m_present(s, t);
        e.is_load = ld;
        e.name    = nm;
        e.data    = '0;
        if (ld) begin
            e.data = ref_mem.exists(wa) ? ref_mem[wa] : defv(wa);
            if (hit) begin
                e.stalls = 0;
                hits++;
                m_touch(s, t);
            end else begin
                e.stalls = lat + 1;
                misses++;
                m_insert(s, t);
            end
        end else begin
            ref_mem[wa] = d;
            e.stalls = lat + 1;
            if (hit) m_touch(s, t);
        end
        sb_q.push_back(e);
        exp_sram = !(ld && hit);
        exp_we   = !ld;
        exp_addr = wa;
        s_lat    = lat;
        mem_r_en = ld;
        mem_w_en = !ld;
        addr     = a;
        wdata    = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 40);
        if (!ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no ready in %0d cycles, expected at most %0d",
                     nm, n, lat + 1);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $fatal(1);
        end
        @(posedge clk);
        #1;
        check({nm, "_hit_cnt"}, 64'(hit_cnt), sat(hits));
        check({nm, "_miss_cnt"}, 64'(miss_cnt), sat(misses));
    endtask

    task automatic go_idle();
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] ra;

    initial begin
        m_clear();
        sram_mem[32'h40] = 32'hDEADBEEF;
        ref_mem[32'h40]  = 32'hDEADBEEF;
        #12;
        check("reset_ready", 64'(ready), 64'(1));
        check("reset_sram_req", 64'(sram_req), 64'(0));
        check("reset_sram_we", 64'(sram_we), 64'(0));
        check("reset_hit_cnt", 64'(hit_cnt), 64'(0));
        check("reset_miss_cnt", 64'(miss_cnt), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(1, 32'h40, 32'h0, 3, "cold_miss");
        issue(1, 32'h40, 32'h0, 1, "repeat_hit");
        issue(1, 32'h140, 32'h0, 2, "conflict_a");
        issue(1, 32'h240, 32'h0, 1, "conflict_b");
        issue(1, 32'h140, 32'h0, 1, "lru_hit");
        issue(1, 32'h40, 32'h0, 2, "evicted_miss");
        issue(0, 32'h40, 32'h12345678, 2, "wt_store");
        issue(1, 32'h40, 32'h0, 1, "wt_load");
        issue(0, 32'h800, 32'hCAFEF00D, 1, "na_store");
        issue(1, 32'h800, 32'h0, 2, "na_load");
        go_idle();

        // Reset in the middle of a READ.
        mon_en   = 1'b0;
        exp_sram = 1;
        exp_we   = 0;
        exp_addr = 32'h2040;
        s_lat    = 100;
        mem_r_en = 1'b1;
        addr     = 32'h2040;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("midread_sram_req", 64'(sram_req), 64'(1));
        mem_r_en = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_drops_sram_req", 64'(sram_req), 64'(0));
        check("rst_ready", 64'(ready), 64'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_clear();
        sb_q.delete();
        mon_en = 1'b1;
        check("rst_hit_cnt", 64'(hit_cnt), 64'(0));
        check("rst_miss_cnt", 64'(miss_cnt), 64'(0));
        issue(1, 32'h40, 32'h0, 1, "post_rst_miss");
        for (int i = 0; i < 5; i++) issue(1, 32'h40, 32'h0, 1, "sat_hit");
        go_idle();

        for (int i = 0; i < 400; i++) begin
            ra = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(15, 17)) << 2)
               | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 7) issue(1, ra, $urandom, $urandom_range(1, 4), "rnd_load");
            else issue(0, ra, $urandom, $urandom_range(1, 4), "rnd_store");
            if ($urandom_range(0, 7) == 0) go_idle();
        end
        go_idle();
        repeat (3) @(posedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
